// File: rtl/proc_pkg.sv
`default_nettype none
// =============================================================================
// Module      : proc_pkg
// Description : Shared processor datapath word width and word type.
// Revision    : 1.0 - initial release
// =============================================================================
package proc_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage
`default_nettype wire

// File: rtl/fifo32_mem.sv
`default_nettype none
// =============================================================================
// Module      : fifo32_mem
// Description : DEPTH x WIDTH register array, one write port, async read port.
// Revision    : 1.0 - initial release
// =============================================================================
module fifo32_mem
    import proc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    // Contents are not reset; the reader masks the output while empty.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo32_rd.sv
`default_nettype none
// =============================================================================
// Module      : fifo32_rd
// Description : First-word-fall-through read buffer, strobe push / valid-ready pop.
// Revision    : 1.0 - initial release
// =============================================================================
module fifo32_rd
    import proc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic                     o_full,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             w_full;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rdata;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_count != '0);
    // A push into a full buffer is dropped even if a pop frees a slot this cycle.
    assign w_push  = i_wr_en & ~w_full & ~clr;
    assign w_pop   = w_valid & i_rd_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (i_wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    fifo32_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wp),
        .i_wdata (i_wr_data),
        .i_raddr (r_rp),
        .o_rdata (w_rdata)
    );

    assign o_full     = w_full;
    assign o_rd_valid = w_valid;
    assign o_rd_data  = w_valid ? w_rdata : '0;
    assign o_count    = r_count;
    assign o_ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fifo32_rd.sv
`default_nettype none
// =============================================================================
// Module      : tb_fifo32_rd
// Description : Directed self-checking bench for fifo32_rd (DEPTH=4).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fifo32_rd;
    import proc_pkg::*;

    logic        clk;
    logic        clr;
    logic        r_wr_en;
    word_t       r_wr_data;
    logic        w_full;
    logic        w_rd_valid;
    logic        r_rd_ready;
    word_t       w_rd_data;
    logic [2:0]  w_count;
    logic        w_ovf;

    int checks   = 0;
    int failures = 0;

    word_t c_vals [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    fifo32_rd #(
        .DEPTH (4),
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .i_wr_en    (r_wr_en),
        .i_wr_data  (r_wr_data),
        .o_full     (w_full),
        .o_rd_valid (w_rd_valid),
        .i_rd_ready (r_rd_ready),
        .o_rd_data  (w_rd_data),
        .o_count    (w_count),
        .o_ovf      (w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input word_t d);
        r_wr_en   = 1'b1;
        r_wr_data = d;
        step();
        r_wr_en   = 1'b0;
    endtask

    initial begin
        clr        = 1'b1;
        r_wr_en    = 1'b0;
        r_wr_data  = '0;
        r_rd_ready = 1'b0;

        #2;
        r_rd_ready = 1'b1;
        step();
        chk_val("rst_valid", 32'(w_rd_valid), 32'd0);
        chk_val("rst_data",  w_rd_data,       32'd0);
        chk_val("rst_count", 32'(w_count),    32'd0);
        r_rd_ready = 1'b0;
        clr        = 1'b0;
        step();
        chk_val("post_rst_valid", 32'(w_rd_valid), 32'd0);
        chk_val("post_rst_full",  32'(w_full),     32'd0);
        chk_val("post_rst_ovf",   32'(w_ovf),      32'd0);
        chk_val("post_rst_data",  w_rd_data,       32'd0);

        // Fill then drain
        for (int i = 0; i < 4; i++) begin
            r_wr_en   = 1'b1;
            r_wr_data = c_vals[i];
            step();
        end
        r_wr_en = 1'b0;
        chk_val("fill_full",  32'(w_full),  32'd1);
        chk_val("fill_count", 32'(w_count), 32'd4);
        chk_val("fill_head",  w_rd_data,    32'h11111111);
        r_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_val("drain_valid", 32'(w_rd_valid), 32'd1);
            chk_val("drain_data",  w_rd_data,       c_vals[i]);
            step();
        end
        chk_val("drain_empty", 32'(w_rd_valid), 32'd0);
        chk_val("drain_zero",  w_rd_data,       32'd0);
        chk_val("drain_count", 32'(w_count),    32'd0);
        r_rd_ready = 1'b0;

        // Overflow: push into full buffer with a concurrent pop is dropped
        for (int i = 0; i < 4; i++) push(c_vals[i]);
        r_wr_en    = 1'b1;
        r_wr_data  = 32'hDEADBEEF;
        r_rd_ready = 1'b1;
        step();
        r_wr_en = 1'b0;
        chk_val("ovf_flag",  32'(w_ovf),   32'd1);
        chk_val("ovf_count", 32'(w_count), 32'd3);
        for (int i = 1; i < 4; i++) begin
            chk_val("ovf_drain", w_rd_data, c_vals[i]);
            step();
        end
        chk_val("ovf_empty",  32'(w_rd_valid), 32'd0);
        chk_val("ovf_sticky", 32'(w_ovf),      32'd1);
        r_rd_ready = 1'b0;

        // Simultaneous push and pop at count 1
        push(32'hA5A5A5A5);
        chk_val("sim_head0", w_rd_data, 32'hA5A5A5A5);
        r_wr_en    = 1'b1;
        r_wr_data  = 32'h5A5A5A5A;
        r_rd_ready = 1'b1;
        step();
        r_wr_en    = 1'b0;
        r_rd_ready = 1'b0;
        chk_val("sim_count", 32'(w_count), 32'd1);
        chk_val("sim_head1", w_rd_data,    32'h5A5A5A5A);
        r_rd_ready = 1'b1;
        step();
        r_rd_ready = 1'b0;
        chk_val("sim_empty", 32'(w_count), 32'd0);

        // Streaming through wrapped pointers: each word is head one cycle after push
        r_rd_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            r_wr_en   = 1'b1;
            r_wr_data = 32'(k);
            step();
            chk_val("wrap_data",  w_rd_data,    32'(k));
            chk_val("wrap_count", 32'(w_count), 32'd1);
        end
        r_wr_en = 1'b0;
        step();
        r_rd_ready = 1'b0;
        chk_val("wrap_end", 32'(w_count), 32'd0);

        // Asynchronous reset mid-operation
        push(32'd1);
        push(32'd2);
        push(32'd3);
        chk_val("mid_count3", 32'(w_count), 32'd3);
        #2;
        clr = 1'b1;
        #1;
        chk_val("mid_count",  32'(w_count),    32'd0);
        chk_val("mid_valid",  32'(w_rd_valid), 32'd0);
        chk_val("mid_data",   w_rd_data,       32'd0);
        chk_val("mid_ovf",    32'(w_ovf),      32'd0);
        clr = 1'b0;
        step();
        push(32'h7);
        chk_val("after_data",  w_rd_data,    32'h7);
        chk_val("after_count", 32'(w_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo32_rd.md
# fifo32_rd

Read-side word buffer between a producer that emits 32-bit words under a single-cycle enable strobe and a consumer that pulls words with a valid/ready handshake. It holds up to DEPTH words in arrival order and presents the oldest one on `rd_data` first-word-fall-through. It sits after pipeline result registers, where the consumer (memory-mapped I/O, stall-capable stage) cannot accept every word on the cycle it is produced.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `WIDTH`, 32: data word width.
- `clk`  in  1: all state updates on rising edge.
- `clr`  in  1: reset, asynchronous, active-high.
- `wr_en`  in  1: push strobe; `wr_data` captured when accepted.
- `wr_data`  in  WIDTH: word to push.
- `full`  out  1: high when count == DEPTH.
- `rd_valid`  out  1: high when count != 0.
- `rd_ready`  in  1: consumer accepts head word this cycle.
- `rd_data`  out  WIDTH: head (oldest) word; 0 when empty.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `ovf`  out  1: sticky; a push was dropped because the buffer was full.

## Operation
- Push accepted = `wr_en & ~full`, evaluated on pre-edge state. A push to a full buffer is dropped, even if a pop happens in the same cycle.
- Pop = `rd_valid & rd_ready`. `rd_ready` while empty has no effect.
- On an accepted push: `mem[wp] <= wr_data`; `wp <= wp+1` mod DEPTH.
- On a pop: `rp <= rp+1` mod DEPTH.
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop.
- Simultaneous push and pop at count == 1: the old head leaves and the new word becomes head on the next cycle. No bypass: a word is never read in the cycle it is pushed.
- `rd_data = rd_valid ? mem[rp] : 0`. This is combinational from registered state, with no combinational path from `wr_*` or `rd_ready`.
- `ovf` sets on any cycle with `wr_en & full`. Only `clr` clears it.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty come from `count`, not from pointer compare.
- Storage contents are not reset. Their values are irrelevant because `rd_data` is masked while empty.

## Timing
- Reset (`clr` high, async, mid-operation included):
  - `wp`, `rp`, `count` and `ovf` go to 0 immediately.
  - Resulting outputs: `full`=0, `rd_valid`=0, `rd_data`=0, `count`=0, `ovf`=0.
  - Pending words are discarded.
  - Pushes and pops are ignored while `clr` is high.
- Push-to-visible latency: 1 cycle. A word pushed at edge N is on `rd_data` with `rd_valid`=1 after edge N when the buffer was empty.
- Pop takes effect at the edge. The next word (or empty) appears after that edge.
- Throughput: 1 push and 1 pop per cycle when 0 < count < DEPTH.
- `full` and `rd_valid` update only after clock edges or `clr`.

## Structure
- Shared package `proc_pkg`: `WORD_W` = 32 constant and the `word_t` typedef. `WIDTH` defaults to `WORD_W`.
- One sub-module, `fifo32_mem`:
  - DEPTH × WIDTH register array.
  - One write port: `we`, `waddr`, `wdata`, written on the rising edge.
  - One asynchronous read port: `raddr` → `rdata`.
- Pointer, count and flag logic live in `fifo32_rd`.

## Test plan
- Reset and empty:
  - Assert `clr`; pulse `rd_ready` → `rd_valid`=0, `rd_data`=0, `count`=0.
  - Release `clr` → outputs stay 0.
- Fill and drain, DEPTH=4:
  - Push 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive edges with `rd_ready`=0 → `full`=1, `count`=4, `rd_data`=0x11111111.
  - Then hold `rd_ready`=1 → data comes out in order over 4 cycles, then `rd_valid`=0.
- Overflow:
  - With the buffer full, push 0xDEADBEEF while `rd_ready`=1 → word dropped, `ovf`=1, `count`=3.
  - Drain → 0xDEADBEEF never appears; `ovf` stays 1 until `clr`.
- Simultaneous push and pop at count 1:
  - Head 0xA5A5A5A5; push 0x5A5A5A5A with `rd_ready`=1 → after the edge `count`=1, `rd_data`=0x5A5A5A5A.
- Wrap-around:
  - Push and pop one word per cycle for 10 cycles with incrementing data 1..10 → output sequence 1..10 with no gaps; `count` never exceeds 1 after the first push.
- Reset mid-operation:
  - With 3 words queued, pulse `clr` between edges → `count`=0, `rd_valid`=0 immediately.
  - Next push 0x7 → `rd_data`=0x7.
